// File: rtl/ts_32to8.sv
// ts_32to8: packet words {sof,data[31:0]} to byte stream {sof,byte}.
// Build option TS_32TO8_RESYNC_EN: a sof word outside HDR restarts the packet.
module ts_32to8 #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk_main,
  input  logic        rst,
  input  logic [32:0] ts_din,
  input  logic        ts_din_en,
  output logic        ts_din_rdy,
  output logic [8:0]  ts_dout,
  output logic        ts_dout_en,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] RDY_MAX = CW'(FIFO_DEPTH - 3);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [5:0]    PAY_LAST = 6'd46;

  typedef enum logic [2:0] {
    S_HDR,
    S_PID,
    S_GBE,
    S_IP,
    S_PORT,
    S_PAY
  } state_e;

  // nb holds the byte count minus one
  typedef struct packed {
    logic        sof;
    logic [1:0]  nb;
    logic [31:0] data;
  } ent_t;

  state_e      state_q, state_d;
  logic [5:0]  pay_q, pay_d;

  logic        hdr_word;
  logic        wr_req;
  ent_t        wr_ent;
  logic        bad_drop;
  logic        sync_drop;

  ent_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ovf;
  logic        wr_do;
  logic        pop;
  ent_t        head;

  ent_t        cur_q, cur_d;
  logic        vld_q, vld_d;
  logic [1:0]  idx_q, idx_d;
  logic        last;
  logic [1:0]  sel;
  logic [7:0]  cur_byte;

  logic [8:0]  dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
  logic        rdy_q, rdy_d;
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

`ifdef TS_32TO8_RESYNC_EN
  assign hdr_word = ts_din[32];
`else
  assign hdr_word = ts_din[32] && (state_q == S_HDR);
`endif

  always_ff @(posedge clk_main) begin
    if (rst) begin
      state_q <= S_HDR;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    if (ts_din_en) begin
      if (hdr_word) begin
        state_d = S_PID;
        pay_d   = '0;
      end else begin
        unique case (state_q)
          S_HDR:  state_d = S_HDR;
          S_PID:  state_d = S_GBE;
          S_GBE:  state_d = S_IP;
          S_IP:   state_d = S_PORT;
          S_PORT: state_d = S_PAY;
          S_PAY: begin
            if (pay_q == PAY_LAST) begin
              state_d = S_HDR;
              pay_d   = '0;
            end else begin
              pay_d = pay_q + 6'd1;
            end
          end
          default: state_d = S_HDR;
        endcase
      end
    end
  end

  always_comb begin
    wr_req    = 1'b0;
    wr_ent    = '0;
    bad_drop  = 1'b0;
    sync_drop = 1'b0;
    if (ts_din_en) begin
      if (hdr_word) begin
        wr_req         = 1'b1;
        wr_ent.sof     = 1'b1;
        wr_ent.nb      = 2'd0;
        wr_ent.data    = {24'h0, ts_din[7:0]};
        sync_drop      = (state_q != S_HDR);
      end else begin
        unique case (state_q)
          S_HDR: bad_drop = 1'b1;
          S_PID, S_PORT: begin
            wr_req      = 1'b1;
            wr_ent.nb   = 2'd1;
            wr_ent.data = {16'h0, ts_din[15:0]};
          end
          S_GBE: begin
            wr_req      = 1'b1;
            wr_ent.nb   = 2'd0;
            wr_ent.data = {24'h0, ts_din[7:0]};
          end
          S_IP, S_PAY: begin
            wr_req      = 1'b1;
            wr_ent.nb   = 2'd3;
            wr_ent.data = ts_din[31:0];
          end
          default: bad_drop = 1'b1;
        endcase
      end
    end
  end

  // Overflowed words are lost but the parser has already advanced
  assign ovf   = wr_req && (cnt_q == FULL);
  assign wr_do = wr_req && !ovf;
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk_main) begin
    if (wr_do) begin
      mem[wr_ptr_q] <= wr_ent;
    end
  end

  always_comb begin
    wr_ptr_d = wr_do ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({wr_do, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign last     = (idx_q == cur_q.nb);
  assign pop      = (cnt_q != '0) && (!vld_q || last);
  assign sel      = cur_q.nb - idx_q;
  assign cur_byte = cur_q.data[{sel, 3'b000} +: 8];

  always_comb begin
    cur_d = cur_q;
    vld_d = vld_q;
    idx_d = idx_q;
    if (pop) begin
      cur_d = head;
      vld_d = 1'b1;
      idx_d = 2'd0;
    end else if (vld_q && !last) begin
      idx_d = idx_q + 2'd1;
    end else if (vld_q) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    dout_en_d = vld_q;
    dout_d    = vld_q ? {cur_q.sof, cur_byte} : 9'h000;
    rdy_d     = (cnt_q <= RDY_MAX);
    drop_sum  = {1'b0, drop_q}
              + 17'(ovf)
              + 17'(bad_drop)
              + 17'(sync_drop);
    drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_main) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      vld_q     <= 1'b0;
      idx_q     <= 2'd0;
      dout_q    <= 9'h000;
      dout_en_q <= 1'b0;
      rdy_q     <= 1'b1;
      drop_q    <= 16'h0000;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      vld_q     <= vld_d;
      idx_q     <= idx_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      rdy_q     <= rdy_d;
      drop_q    <= drop_d;
    end
  end

  assign ts_dout    = dout_q;
  assign ts_dout_en = dout_en_q;
  assign ts_din_rdy = rdy_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ts_32to8.sv
// tb_ts_32to8: directed stimulus with byte scoreboard for ts_32to8.
// Second instance with an 8-entry FIFO exercises overflow.
module tb_ts_32to8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [32:0] din;
  logic        din_en;
  logic        rdy;
  logic [8:0]  dout;
  logic        dout_en;
  logic [15:0] drop;

  logic [32:0] s_din;
  logic        s_en;
  logic        s_rdy;
  logic [8:0]  s_dout;
  logic        s_dout_en;
  logic [15:0] s_drop;

  ts_32to8 #(.FIFO_DEPTH(64)) u_dut (
    .clk_main   (clk),
    .rst        (rst),
    .ts_din     (din),
    .ts_din_en  (din_en),
    .ts_din_rdy (rdy),
    .ts_dout    (dout),
    .ts_dout_en (dout_en),
    .drop_cnt   (drop)
  );

  ts_32to8 #(.FIFO_DEPTH(8)) u_small (
    .clk_main   (clk),
    .rst        (rst),
    .ts_din     (s_din),
    .ts_din_en  (s_en),
    .ts_din_rdy (s_rdy),
    .ts_dout    (s_dout),
    .ts_dout_en (s_dout_en),
    .drop_cnt   (s_drop)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int first_cyc = -1;
  int run_len = 0;
  int sof_cnt = 0;
  int byte_cnt = 0;
  int n_pushed = 0;
  bit rdy_low = 1'b0;
  bit mon_en = 1'b0;

  logic [8:0] exp_q [$];
  int         runs_q [$];
  logic [8:0] s_cap [$];
  logic [7:0] pa [198];
  logic [7:0] pb [198];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int w_off(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 4;
      4: return 8;
      default: return 10 + 4 * (i - 5);
    endcase
  endfunction

  function automatic int w_len(input int i);
    case (i)
      0, 2: return 1;
      1, 4: return 2;
      default: return 4;
    endcase
  endfunction

  // Insignificant upper bytes carry junk that must never reach the output
  function automatic logic [32:0] word_of(input logic [7:0] b [198],
                                          input int i);
    logic [31:0] d;
    d = 32'hEEEE_EEEE;
    for (int j = 0; j < w_len(i); j++)
      d[8*(w_len(i)-1-j) +: 8] = b[w_off(i)+j];
    return {(i == 0), d};
  endfunction

  task automatic make_pkt(input int id, output logic [7:0] b [198]);
    for (int j = 0; j < 198; j++) b[j] = 8'(id * 37 + j * 11 + 3);
    if (id == 0) begin
      b[0] = 8'h5A; b[1] = 8'h1F; b[2] = 8'hFF; b[3] = 8'h02;
      b[4] = 8'hC0; b[5] = 8'hA8; b[6] = 8'h00; b[7] = 8'h01;
      b[8] = 8'h12; b[9] = 8'h34;
      for (int j = 0; j < 188; j++) b[10+j] = 8'(j);
    end
  endtask

  task automatic push_exp(input logic [7:0] b [198], input int i);
    for (int j = 0; j < w_len(i); j++) begin
      exp_q.push_back({(i == 0 && j == 0), b[w_off(i)+j]});
      n_pushed++;
    end
  endtask

  task automatic send(input logic [32:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy && t < 1000) begin
      din_en = 1'b0;
      t++;
      @(negedge clk);
    end
    if (t >= 1000) chk("rdy_timeout", 64'(t), 64'd0);
    din    = w;
    din_en = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] b [198], input int from,
                          input int to);
    for (int i = from; i <= to; i++) begin
      send(word_of(b, i));
      push_exp(b, i);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    din_en = 1'b0;
    din    = '0;
  endtask

  task automatic clr();
    runs_q.delete();
    run_len   = 0;
    sof_cnt   = 0;
    byte_cnt  = 0;
    n_pushed  = 0;
    first_cyc = -1;
    rdy_low   = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dout_en) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_en = 1'b0; din = '0;
    s_en = 1'b0; s_din = '0;
    @(posedge clk);
    #1;
    exp_q.delete();
    s_cap.delete();
    @(negedge clk);
    rst = 1'b0;
    clr();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rdy === 1'b0) rdy_low = 1'b1;
      if (dout_en === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        run_len++;
        byte_cnt++;
        if (dout[8]) sof_cnt++;
        chk("byte_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("dout", 64'(dout), 64'(exp_q.pop_front()));
      end else begin
        chk("dout_idle", 64'(dout), 64'd0);
        if (run_len > 0) begin
          runs_q.push_back(run_len);
          run_len = 0;
        end
      end
      if (s_dout_en === 1'b1) s_cap.push_back(s_dout);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int t;
    int ds;
    logic [32:0] w;
    rst = 1'b1;
    din = '0; din_en = 1'b0;
    s_din = '0; s_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_en", 64'(dout_en), 64'd0);
    chk("rst_rdy", 64'(rdy), 64'd1);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_s_rdy", 64'(s_rdy), 64'd1);
    chk("rst_s_drop", 64'(s_drop), 64'd0);
    rst = 1'b0;
    clr();
    mon_en = 1'b1;

    // single packet with known field values
    make_pkt(0, pa);
    k = 0;
    for (int i = 0; i < 52; i++) begin
      send(word_of(pa, i));
      if (i == 0) k = cyc + 1;
      push_exp(pa, i);
    end
    idle();
    wait_drain();
    chk("latency", 64'(first_cyc - k), 64'd2);
    chk("p1_runs", 64'(runs_q.size()), 64'd1);
    chk("p1_run_len", 64'(runs_q[0]), 64'd198);
    chk("p1_sof", 64'(sof_cnt), 64'd1);
    chk("p1_drop", 64'(drop), 64'd0);

    // four packets back to back
    clr();
    for (int p = 0; p < 4; p++) begin
      make_pkt(p + 1, pa);
      send_pkt(pa, 0, 51);
    end
    idle();
    wait_drain();
    chk("p4_rdy_low", 64'(rdy_low), 64'd1);
    chk("p4_runs", 64'(runs_q.size()), 64'd1);
    chk("p4_run_len", 64'(runs_q[0]), 64'd792);
    chk("p4_sof", 64'(sof_cnt), 64'd4);
    chk("p4_drop", 64'(drop), 64'd0);

    // word without sof while idle in HDR
    do_reset();
    send({1'b0, 32'h0000_005A});
    idle();
    repeat (10) @(negedge clk);
    chk("bad_drop", 64'(drop), 64'd1);
    chk("bad_no_out", 64'(byte_cnt), 64'd0);
    make_pkt(5, pa);
    send_pkt(pa, 0, 51);
    idle();
    wait_drain();
    chk("bad_next_run", 64'(runs_q[0]), 64'd198);
    chk("bad_next_sof", 64'(sof_cnt), 64'd1);
    chk("bad_drop_hold", 64'(drop), 64'd1);

    // sof word injected as payload word 10
    do_reset();
    make_pkt(6, pa);
    make_pkt(7, pb);
    send_pkt(pa, 0, 14);
`ifdef TS_32TO8_RESYNC_EN
    send(word_of(pb, 0));
    push_exp(pb, 0);
    send_pkt(pb, 1, 51);
    idle();
    wait_drain();
    chk("rs_bytes", 64'(byte_cnt), 64'(n_pushed));
    chk("rs_total", 64'(byte_cnt), 64'd248);
    chk("rs_sof", 64'(sof_cnt), 64'd2);
    chk("rs_drop", 64'(drop), 64'd1);
`else
    w = word_of(pa, 15);
    w[32] = 1'b1;
    send(w);
    push_exp(pa, 15);
    send_pkt(pa, 16, 51);
    idle();
    wait_drain();
    chk("rs_bytes", 64'(byte_cnt), 64'(n_pushed));
    chk("rs_total", 64'(byte_cnt), 64'd198);
    chk("rs_sof", 64'(sof_cnt), 64'd1);
    chk("rs_drop", 64'(drop), 64'd0);
`endif

    // overflow on the 8-entry instance, rdy ignored
    do_reset();
    make_pkt(8, pa);
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      s_din = word_of(pa, i);
      s_en  = 1'b1;
    end
    @(negedge clk);
    s_en = 1'b0;
    repeat (300) @(negedge clk);
    chk("ovf_some", 64'(s_drop > 0), 64'd1);
    chk("ovf_bytes", 64'(s_cap.size()), 64'(198 - 4 * int'(s_drop)));
    chk("ovf_sof", 64'(s_cap[0]), 64'({1'b1, pa[0]}));
    for (int j = 1; j < 10; j++)
      chk("ovf_hdr", 64'(s_cap[j]), 64'({1'b0, pa[j]}));
    s_cap.delete();
    ds = int'(s_drop);
    make_pkt(9, pb);
    for (int i = 0; i < 52; i++) begin
      t = 0;
      @(negedge clk);
      while (!s_rdy && t < 1000) begin
        s_en = 1'b0;
        t++;
        @(negedge clk);
      end
      if (t >= 1000) chk("s_rdy_timeout", 64'(t), 64'd0);
      s_din = word_of(pb, i);
      s_en  = 1'b1;
    end
    @(negedge clk);
    s_en = 1'b0;
    repeat (300) @(negedge clk);
    chk("ovf_next_len", 64'(s_cap.size()), 64'd198);
    for (int j = 0; j < 198; j++)
      chk("ovf_next_byte", 64'(s_cap[j]), 64'({(j == 0), pb[j]}));
    chk("ovf_drop_hold", 64'(s_drop), 64'(ds));

    // reset while payload is streaming
    do_reset();
    send({1'b0, 32'h0000_0011});
    make_pkt(10, pa);
    send_pkt(pa, 0, 20);
    idle();
    repeat (3) @(negedge clk);
    chk("pre_rst_drop", 64'(drop), 64'd1);
    chk("pre_rst_en", 64'(dout_en), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_en", 64'(dout_en), 64'd0);
    chk("mid_rst_dout", 64'(dout), 64'd0);
    chk("mid_rst_drop", 64'(drop), 64'd0);
    chk("mid_rst_rdy", 64'(rdy), 64'd1);
    rst = 1'b0;
    clr();
    make_pkt(11, pa);
    send_pkt(pa, 0, 51);
    idle();
    wait_drain();
    chk("post_rst_run", 64'(runs_q[0]), 64'd198);
    chk("post_rst_sof", 64'(sof_cnt), 64'd1);
    chk("post_rst_bytes", 64'(byte_cnt), 64'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
